// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: single-port synchronous data RAM with request/ready handshake,
// byte-lane writes, two-edge registered read response and zero-fill after reset.
// Optional macro DATA_MEM_BOUNDS_CHECK_EN: out-of-range requests raise o_error and
// read as zero instead of aliasing modulo DEPTH.
module data_memory_ctrl #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 64
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_req_valid,
  input  logic                i_req_write,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_byte_en,
  output logic                o_req_ready,
  output logic                o_resp_valid,
  output logic [DATA_W-1:0]   o_rdata,
  output logic                o_busy,
  output logic                o_error
);
  localparam int NB    = DATA_W / 8;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic               r_req_ready;
  logic               r_busy;
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [DATA_W-1:0]  r_rd_data;
  logic               r_rd_pend;
  logic               r_resp_valid;
  logic [DATA_W-1:0]  r_rdata;
  logic               w_wr;
  logic               w_rd;
  logic               w_ok;
  logic [31:0]        w_addr32;
  logic [PTR_W-1:0]   w_idx;

  assign w_wr     = i_req_valid && r_req_ready && i_req_write;
  assign w_rd     = i_req_valid && r_req_ready && !i_req_write;
  assign w_addr32 = 32'(i_addr);

`ifdef DATA_MEM_BOUNDS_CHECK_EN
  logic r_err_pend;
  logic r_error;
  assign w_ok    = w_addr32 < 32'(DEPTH);
  assign w_idx   = PTR_W'(w_addr32);
  assign o_error = r_error;
`else
  assign w_ok    = 1'b1;
  assign w_idx   = PTR_W'(w_addr32 % 32'(DEPTH));
  assign o_error = 1'b0;
`endif

  assign o_req_ready  = r_req_ready;
  assign o_busy       = r_busy;
  assign o_resp_valid = r_resp_valid;
  assign o_rdata      = r_rdata;

  // Control FSM: walk the fill pointer over every word once, then accept requests forever
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_CLEAR;
      r_ptr       <= '0;
      r_req_ready <= 1'b0;
      r_busy      <= 1'b1;
    end else if (r_state == S_CLEAR) begin
      r_ptr <= r_ptr + PTR_W'(1);
      if (r_ptr == PTR_W'(DEPTH - 1)) begin
        r_state     <= S_IDLE;
        r_req_ready <= 1'b1;
        r_busy      <= 1'b0;
      end
    end
  end

  // Storage: zero-fill during CLEAR, byte-lane writes and synchronous read capture afterwards
  always_ff @(posedge i_clock) begin
    if (r_state == S_CLEAR)
      r_mem[r_ptr] <= '0;
    else if (w_wr && w_ok)
      for (int k = 0; k < NB; k++)
        if (i_byte_en[k]) r_mem[w_idx][8*k +: 8] <= i_wdata[8*k +: 8];
    if (w_rd) r_rd_data <= w_ok ? r_mem[w_idx] : '0;
  end

  // Request tracking: remember an accepted read (and range fault) until the response edge
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_pend  <= 1'b0;
`ifdef DATA_MEM_BOUNDS_CHECK_EN
      r_err_pend <= 1'b0;
`endif
    end else begin
      r_rd_pend  <= w_rd;
`ifdef DATA_MEM_BOUNDS_CHECK_EN
      r_err_pend <= i_req_valid && r_req_ready && !w_ok;
`endif
    end
  end

  // Response stage: one-cycle valid pulse, read data held until the next response
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
`ifdef DATA_MEM_BOUNDS_CHECK_EN
      r_error      <= 1'b0;
`endif
    end else begin
      r_resp_valid <= r_rd_pend;
      if (r_rd_pend) r_rdata <= r_rd_data;
`ifdef DATA_MEM_BOUNDS_CHECK_EN
      r_error      <= r_err_pend;
`endif
    end
  end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: randomized and directed checks of data_memory_ctrl against a word-array model
module tb_data_memory_ctrl;
  logic        i_clock = 1'b0;
  logic        i_reset_n;
  logic        i_req_valid;
  logic        i_req_write;
  logic [7:0]  i_addr;
  logic [23:0] i_wdata;
  logic [2:0]  i_byte_en;
  logic        o_req_ready;
  logic        o_resp_valid;
  logic [23:0] o_rdata;
  logic        o_busy;
  logic        o_error;

  int n_chk = 0;
  int n_fail = 0;

  logic [23:0] mem_m [64];
  int          clr;
  logic        p_rd, p_err;
  logic [23:0] p_data;
  logic        e_valid, e_err;
  logic [23:0] e_rdata;

  data_memory_ctrl dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_req_valid(i_req_valid),
    .i_req_write(i_req_write), .i_addr(i_addr), .i_wdata(i_wdata), .i_byte_en(i_byte_en),
    .o_req_ready(o_req_ready), .o_resp_valid(o_resp_valid), .o_rdata(o_rdata),
    .o_busy(o_busy), .o_error(o_error)
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 32'(o_resp_valid), 32'(e_valid));
    chk({tag, ".rdata"}, 32'(o_rdata), 32'(e_rdata));
    chk({tag, ".error"}, 32'(o_error), 32'(e_err));
    chk({tag, ".ready"}, 32'(o_req_ready), 32'(clr >= 64));
    chk({tag, ".busy"}, 32'(o_busy), 32'(clr < 64));
  endtask

  // One clock: present a request, advance the model by one edge, compare everything
  task automatic step(input logic v, input logic w, input logic [7:0] a,
                      input logic [23:0] d, input logic [2:0] be, input string tag);
    logic acc, oob;
    int   idx;
    i_req_valid = v;
    i_req_write = w;
    i_addr      = a;
    i_wdata     = d;
    i_byte_en   = be;
    acc = v && (clr >= 64);
    @(posedge i_clock);
    #1;
    e_valid = p_rd;
    e_err   = p_err;
    if (p_rd) e_rdata = p_data;
    p_rd  = 1'b0;
    p_err = 1'b0;
    if (clr < 64) clr++;
    if (acc) begin
      oob = 1'b0;
      idx = int'(a) % 64;
`ifdef DATA_MEM_BOUNDS_CHECK_EN
      oob = a >= 8'd64;
      idx = int'(a);
`endif
      if (w && !oob)
        for (int k = 0; k < 3; k++)
          if (be[k]) mem_m[idx][8*k +: 8] = d[8*k +: 8];
      if (!w) begin
        p_rd   = 1'b1;
        p_data = oob ? 24'h0 : mem_m[idx];
      end
      p_err = oob;
    end
    check_outputs(tag);
  endtask

  task automatic nop(input string tag);
    step(1'b0, 1'b0, 8'd0, 24'h0, 3'b000, tag);
  endtask

  // Asynchronous reset applied away from the clock edge; outputs must clear at once
  task automatic do_reset(input string tag);
    i_req_valid = 1'b0;
    i_reset_n   = 1'b0;
    #1;
    clr     = 0;
    p_rd    = 1'b0;
    p_err   = 1'b0;
    e_valid = 1'b0;
    e_err   = 1'b0;
    e_rdata = 24'h0;
    for (int i = 0; i < 64; i++) mem_m[i] = 24'h0;
    check_outputs(tag);
    @(posedge i_clock);
    #1;
    check_outputs({tag, ".held"});
    i_reset_n = 1'b1;
  endtask

  initial begin
    i_reset_n   = 1'b0;
    i_req_valid = 1'b0;
    i_req_write = 1'b0;
    i_addr      = 8'd0;
    i_wdata     = 24'h0;
    i_byte_en   = 3'b000;
    clr = 0; p_rd = 0; p_err = 0; e_valid = 0; e_err = 0; e_rdata = 0; p_data = 0;
    @(posedge i_clock);
    #1;
    do_reset("rst0");
    for (int i = 0; i < 64; i++)
      if (i == 10) step(1'b1, 1'b1, 8'd3, 24'hFFFFFF, 3'b111, "fill_wr3");
      else nop("fill");
    chk("fill_done_ready", 32'(o_req_ready), 32'd1);
    step(1'b1, 1'b0, 8'd5, 24'h0, 3'b000, "rd5");
    nop("rd5_resp");
    chk("rd5_const", 32'(o_rdata), 32'h000000);
    step(1'b1, 1'b1, 8'd2, 24'h123456, 3'b111, "wr2");
    step(1'b1, 1'b0, 8'd2, 24'h0, 3'b000, "rd2");
    nop("rd2_resp");
    chk("rd2_const", 32'(o_rdata), 32'h123456);
    chk("rd2_valid", 32'(o_resp_valid), 32'd1);
    nop("rd2_after");
    chk("rd2_pulse_end", 32'(o_resp_valid), 32'd0);
    chk("rd2_hold", 32'(o_rdata), 32'h123456);
    step(1'b1, 1'b1, 8'd2, 24'hABCDEF, 3'b010, "wr2_lane1");
    step(1'b1, 1'b0, 8'd2, 24'h0, 3'b000, "rd2b");
    nop("rd2b_resp");
    chk("rd2b_const", 32'(o_rdata), 32'h12CD56);
    step(1'b1, 1'b0, 8'd3, 24'h0, 3'b000, "rd3");
    nop("rd3_resp");
    chk("rd3_const", 32'(o_rdata), 32'h000000);
    step(1'b1, 1'b1, 8'd9, 24'h777777, 3'b000, "wr9_noen");
    step(1'b1, 1'b0, 8'd9, 24'h0, 3'b000, "rd9");
    nop("rd9_resp");
    chk("rd9_const", 32'(o_rdata), 32'h000000);
    step(1'b1, 1'b1, 8'd70, 24'h0000AA, 3'b111, "wr70");
`ifdef DATA_MEM_BOUNDS_CHECK_EN
    step(1'b1, 1'b0, 8'd70, 24'h0, 3'b000, "rd70");
    chk("wr70_err", 32'(o_error), 32'd1);
    nop("rd70_resp");
    chk("rd70_const", 32'(o_rdata), 32'h000000);
    chk("rd70_err", 32'(o_error), 32'd1);
    step(1'b1, 1'b0, 8'd6, 24'h0, 3'b000, "rd6");
    nop("rd6_resp");
    chk("rd6_const", 32'(o_rdata), 32'h000000);
`else
    step(1'b1, 1'b0, 8'd6, 24'h0, 3'b000, "rd6");
    chk("wr70_err", 32'(o_error), 32'd0);
    nop("rd6_resp");
    chk("rd6_const", 32'(o_rdata), 32'h0000AA);
`endif
    step(1'b1, 1'b0, 8'd2, 24'h0, 3'b000, "rd_then_rst");
    do_reset("rst_mid");
    for (int i = 0; i < 64; i++) begin
      nop("refill");
      if (i == 0) chk("rst_no_pulse", 32'(o_resp_valid), 32'd0);
    end
    step(1'b1, 1'b0, 8'd2, 24'h0, 3'b000, "rd2_cleared");
    nop("rd2_cleared_resp");
    chk("rd2_cleared_const", 32'(o_rdata), 32'h000000);
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 79)), 24'($urandom), 3'($urandom_range(0, 7)), "rnd");
    nop("drain");
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
